wb_stage_mp: RTL and testbench

- Parametrised multi-lane writeback stage. Accepts one bundle of LANES results per handshake from MEM/WB.
- Selects ALU or memory data per lane and drives RF_PORTS register-file write ports.
- When LANES > RF_PORTS, it serialises the surplus lanes over later cycles and back-pressures upstream.
- Sits between the MEM/WB pipeline register and the register file.

---
 rtl/wb_stage_mp_pkg.sv | 13 +
 rtl/wb_stage_mp_lane_pick.sv | 25 ++
 rtl/wb_stage_mp.sv | 95 +++++++++
 tb/tb_wb_stage_mp.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_mp_pkg.sv
// wb_pkg: writeback select and load-mode constants; extend_load exists only with WB_LOAD_EXT_EN
package wb_pkg;
  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_MEM = 1'b1;
  localparam logic [1:0] LD_FULL = 2'b00;
  localparam logic [1:0] LD_BYTE_U = 2'b01;
  localparam logic [1:0] LD_BYTE_S = 2'b10;
`ifdef WB_LOAD_EXT_EN
  function automatic logic [63:0] extend_load(input logic [63:0] w, input logic [1:0] mode);
    return mode == LD_BYTE_U ? {56'b0, w[7:0]} : mode == LD_BYTE_S ? {{56{w[7]}}, w[7:0]} : w;
  endfunction
`endif
endpackage

// File: rtl/wb_stage_mp_lane_pick.sv
// wb_lane_pick: assigns the lowest set mask bits to RF_PORTS slots in ascending lane order
module wb_lane_pick #(
  parameter int LANES = 2,
  parameter int RF_PORTS = 1,
  parameter int IDX_W = 1
) (
  input  logic [LANES-1:0]          mask,
  output logic [RF_PORTS*IDX_W-1:0] idx,
  output logic [RF_PORTS-1:0]       vld,
  output logic [LANES-1:0]          rem
);
  logic [LANES-1:0] m;
  always_comb begin
    m = mask;
    idx = '0;
    vld = '0;
    for (int p = 0; p < RF_PORTS; p++) begin
      for (int l = LANES - 1; l >= 0; l--)
        if (m[l]) idx[p*IDX_W +: IDX_W] = IDX_W'(l);
      vld[p] = |m;
      m = m & (m - LANES'(1));
    end
    rem = m;
  end
endmodule

// File: rtl/wb_stage_mp.sv
// wb_stage_mp: multi-lane writeback stage serialising LANES results onto RF_PORTS write ports (load extension under WB_LOAD_EXT_EN)
module wb_stage_mp
  import wb_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int LANES = 2,
  parameter int RF_PORTS = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*DATA_W-1:0]    in_alu_res,
  input  logic [LANES*DATA_W-1:0]    in_mem_res,
  input  logic [LANES*ADDR_W-1:0]    in_dest,
  input  logic [LANES-1:0]           in_alu_bar_mem,
  input  logic [LANES-1:0]           in_wb_en,
`ifdef WB_LOAD_EXT_EN
  input  logic [2*LANES-1:0]         in_ld_mode,
`endif
  output logic [RF_PORTS*DATA_W-1:0] wb_data,
  output logic [RF_PORTS*ADDR_W-1:0] wb_dest,
  output logic [RF_PORTS-1:0]        regfile_en
);
  localparam int IDX_W = LANES > 1 ? $clog2(LANES) : 1;
  logic acc;
  logic [LANES-1:0] pend, cand, rem;
  logic [DATA_W-1:0] mem_l;
  logic [LANES*DATA_W-1:0] sel_data, hold_data, src_data;
  logic [LANES*ADDR_W-1:0] hold_dest, src_dest;
  logic [RF_PORTS*IDX_W-1:0] idx;
  logic [RF_PORTS-1:0] vld, en_n;
  logic [RF_PORTS*DATA_W-1:0] data_n;
  logic [RF_PORTS*ADDR_W-1:0] dest_n;
  assign in_ready = ~|pend;
  assign acc = in_valid && in_ready;
  // accept cycle issues straight from the inputs so the first write lands one cycle later
  assign cand = acc ? in_wb_en : pend;
  assign src_data = acc ? sel_data : hold_data;
  assign src_dest = acc ? in_dest : hold_dest;
  always_comb begin
    sel_data = '0;
    mem_l = '0;
    for (int l = 0; l < LANES; l++) begin
`ifdef WB_LOAD_EXT_EN
      mem_l = DATA_W'(extend_load(64'(in_mem_res[l*DATA_W +: DATA_W]), in_ld_mode[l*2 +: 2]));
`else
      mem_l = in_mem_res[l*DATA_W +: DATA_W];
`endif
      sel_data[l*DATA_W +: DATA_W] = in_alu_bar_mem[l] == WB_SEL_MEM ? mem_l : in_alu_res[l*DATA_W +: DATA_W];
    end
  end
  wb_lane_pick #(.LANES(LANES), .RF_PORTS(RF_PORTS), .IDX_W(IDX_W)) u_pick (
    .mask(cand),
    .idx(idx),
    .vld(vld),
    .rem(rem)
  );
  always_comb begin
    data_n = '0;
    dest_n = '0;
    en_n = '0;
    for (int p = 0; p < RF_PORTS; p++) begin
      if (vld[p]) begin
        data_n[p*DATA_W +: DATA_W] = src_data[int'(idx[p*IDX_W +: IDX_W])*DATA_W +: DATA_W];
        dest_n[p*ADDR_W +: ADDR_W] = src_dest[int'(idx[p*IDX_W +: IDX_W])*ADDR_W +: ADDR_W];
        en_n[p] = 1'b1;
      end
    end
    // a higher port carries a higher lane, so it wins a same-cycle destination clash
    for (int p = 0; p < RF_PORTS; p++)
      for (int q = p + 1; q < RF_PORTS; q++)
        if (vld[p] && vld[q] && dest_n[p*ADDR_W +: ADDR_W] == dest_n[q*ADDR_W +: ADDR_W]) en_n[p] = 1'b0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
      hold_data <= '0;
      hold_dest <= '0;
      wb_data <= '0;
      wb_dest <= '0;
      regfile_en <= '0;
    end else begin
      pend <= rem;
      if (acc) begin
        hold_data <= sel_data;
        hold_dest <= in_dest;
      end
      wb_data <= data_n;
      wb_dest <= dest_n;
      regfile_en <= en_n;
    end
  end
endmodule

// File: tb/tb_wb_stage_mp.sv
// tb_wb_stage_mp: scoreboard bench for wb_stage_mp with one and two write ports
module tb_wb_stage_mp;
  typedef struct {
    logic [1:0] en;
    logic [1:0] sel;
    logic [15:0] a0, a1, m0, m1;
    logic [2:0] d0, d1;
    logic [3:0] md;
  } vec_t;
  typedef struct {
    int port;
    logic [15:0] data;
    logic [2:0] dest;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic v1 = 1'b0, v2 = 1'b0, r1, r2;
  logic [31:0] alu = '0, mem = '0;
  logic [5:0] dest = '0;
  logic [1:0] sel = '0, wen = '0;
  logic [3:0] mode = '0;
  logic [15:0] d1;
  logic [2:0] a1;
  logic e1;
  logic [31:0] d2;
  logic [5:0] a2;
  logic [1:0] e2;

  wr_t q1[$], q2[$];
  wr_t mw;
  int total = 0, bad = 0;

  wb_stage_mp #(.DATA_W(16), .ADDR_W(3), .LANES(2), .RF_PORTS(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1),
    .in_alu_res(alu), .in_mem_res(mem), .in_dest(dest), .in_alu_bar_mem(sel), .in_wb_en(wen),
`ifdef WB_LOAD_EXT_EN
    .in_ld_mode(mode),
`endif
    .wb_data(d1), .wb_dest(a1), .regfile_en(e1)
  );

  wb_stage_mp #(.DATA_W(16), .ADDR_W(3), .LANES(2), .RF_PORTS(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2),
    .in_alu_res(alu), .in_mem_res(mem), .in_dest(dest), .in_alu_bar_mem(sel), .in_wb_en(wen),
`ifdef WB_LOAD_EXT_EN
    .in_ld_mode(mode),
`endif
    .wb_data(d2), .wb_dest(a2), .regfile_en(e2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] lane_val(input vec_t v, input int l);
    logic [15:0] a, m;
    a = l != 0 ? v.a1 : v.a0;
    m = l != 0 ? v.m1 : v.m0;
    if (!v.sel[l]) return a;
`ifdef WB_LOAD_EXT_EN
    if (v.md[l*2 +: 2] == 2'b01) return {8'h00, m[7:0]};
    if (v.md[l*2 +: 2] == 2'b10) return {{8{m[7]}}, m[7:0]};
`endif
    return m;
  endfunction

  task automatic push(input int which, input vec_t v);
    logic coll;
    coll = (&v.en) && v.d0 == v.d1;
    if (which == 1) begin
      if (v.en[0]) q1.push_back('{0, lane_val(v, 0), v.d0});
      if (v.en[1]) q1.push_back('{0, lane_val(v, 1), v.d1});
    end else begin
      if (v.en[0] && !coll) q2.push_back('{0, lane_val(v, 0), v.d0});
      if (v.en[1]) q2.push_back('{v.en[0] ? 1 : 0, lane_val(v, 1), v.d1});
    end
  endtask

  task automatic send(input int which, input vec_t v, input bit hold);
    int n;
    n = 0;
    @(negedge clk);
    while (!(which == 1 ? r1 : r2) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL send timeout: in_ready stuck at 0, want 1");
    end
    alu = {v.a1, v.a0};
    mem = {v.m1, v.m0};
    dest = {v.d1, v.d0};
    sel = v.sel;
    wen = v.en;
    mode = v.md;
    push(which, v);
    if (which == 1) v1 = 1'b1;
    else v2 = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) begin
      v1 = 1'b0;
      v2 = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (e1) begin
        if (q1.size() == 0) begin
          total++;
          bad++;
          $display("FAIL u1 unexpected write: data %h dest %0d, want none", d1, a1);
        end else begin
          mw = q1.pop_front();
          chk("u1 data", 32'(d1), 32'(mw.data));
          chk("u1 dest", 32'(a1), 32'(mw.dest));
        end
      end else begin
        chk("u1 idle data", 32'(d1), 0);
        chk("u1 idle dest", 32'(a1), 0);
      end
      for (int p = 0; p < 2; p++) begin
        if (e2[p]) begin
          if (q2.size() == 0) begin
            total++;
            bad++;
            $display("FAIL u2 unexpected write: port %0d data %h, want none", p, d2[p*16 +: 16]);
          end else begin
            mw = q2.pop_front();
            chk("u2 port", p, mw.port);
            chk("u2 data", 32'(d2[p*16 +: 16]), 32'(mw.data));
            chk("u2 dest", 32'(a2[p*3 +: 3]), 32'(mw.dest));
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  vec_t va, vc, vs, vz, vr, tbl[8];
  wr_t junk;

  initial begin
    va = '{2'b11, 2'b10, 16'h1111, 16'h0000, 16'h0000, 16'hBEEF, 3'd2, 3'd5, 4'h0};
    vc = va;
    vc.d0 = 3'd3;
    vc.d1 = 3'd3;
    vs = va;
    vs.en = 2'b10;
    vz = va;
    vz.en = 2'b00;
    tbl[0] = '{2'b11, 2'b00, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 3'd1, 3'd1, 4'h0};
    tbl[1] = '{2'b01, 2'b01, 16'hA0A0, 16'hB0B0, 16'hC0C0, 16'hD0D0, 3'd7, 3'd0, 4'h0};
    tbl[2] = '{2'b10, 2'b11, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 3'd4, 3'd6, 4'h0};
    tbl[3] = '{2'b00, 2'b11, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 3'd1, 3'd2, 4'h0};
    tbl[4] = '{2'b11, 2'b11, 16'h0F0F, 16'hF0F0, 16'h5555, 16'hAAAA, 3'd0, 3'd7, 4'h0};
    tbl[5] = '{2'b11, 2'b01, 16'h2222, 16'h3333, 16'h4444, 16'h6666, 3'd5, 3'd5, 4'h0};
    tbl[6] = '{2'b01, 2'b00, 16'h7777, 16'h8888, 16'h9999, 16'hAAAA, 3'd3, 3'd3, 4'h0};
    tbl[7] = '{2'b11, 2'b10, 16'hCAFE, 16'hF00D, 16'hDEAD, 16'hBEEF, 3'd6, 3'd1, 4'h0};

    idle(3);
    chk("reset u1 en", 32'(e1), 0);
    chk("reset u1 data", 32'(d1), 0);
    chk("reset u1 dest", 32'(a1), 0);
    chk("reset u2 en", 32'(e2), 0);
    chk("reset u2 data", d2, 0);
    rst = 1'b0;
    #1;
    chk("ready after reset u1", 32'(r1), 1);
    chk("ready after reset u2", 32'(r2), 1);

    send(1, va, 0);
    chk("ser t+1 en", 32'(e1), 1);
    chk("ser t+1 data", 32'(d1), 32'h1111);
    chk("ser t+1 dest", 32'(a1), 2);
    chk("ser t+1 ready", 32'(r1), 0);
    @(posedge clk);
    #1;
    chk("ser t+2 en", 32'(e1), 1);
    chk("ser t+2 data", 32'(d1), 32'hBEEF);
    chk("ser t+2 dest", 32'(a1), 5);
    chk("ser t+2 ready", 32'(r1), 1);
    idle(3);

    send(2, va, 0);
    chk("par en", 32'(e2), 3);
    chk("par data", d2, 32'hBEEF_1111);
    chk("par ready", 32'(r2), 1);
    send(2, vc, 0);
    chk("coll en", 32'(e2), 2);
    chk("coll dest", 32'(a2[5:3]), 3);
    idle(3);

    send(1, vs, 0);
    chk("sparse en", 32'(e1), 1);
    chk("sparse data", 32'(d1), 32'hBEEF);
    chk("sparse dest", 32'(a1), 5);
    chk("sparse ready", 32'(r1), 1);
    send(1, vz, 0);
    chk("zero en", 32'(e1), 0);
    chk("zero ready", 32'(r1), 1);
    @(posedge clk);
    #1;
    chk("zero en t+2", 32'(e1), 0);
    idle(3);

    send(1, va, 0);
    junk = q1.pop_back();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst en", 32'(e1), 0);
    chk("midrst data", 32'(d1), 0);
    chk("midrst dest", 32'(a1), 0);
    idle(2);
    rst = 1'b0;
    #1;
    chk("midrst ready", 32'(r1), 1);
    idle(5);
    chk("midrst queue", q1.size(), 0);

    for (int b = 0; b < 3; b++) begin
      vr = va;
      vr.a0 = 16'(16'h0100 * (b + 1));
      vr.m1 = 16'(16'h0A00 + b);
      vr.d0 = 3'(b);
      vr.d1 = 3'(b + 4);
      send(1, vr, b < 2);
    end
    idle(6);
    chk("b2b queue", q1.size(), 0);

    for (int i = 0; i < 8; i++) send(1, tbl[i], i < 7);
    for (int i = 0; i < 8; i++) send(2, tbl[i], i < 7);
    for (int i = 0; i < 24; i++) begin
      vr = '{2'($urandom), 2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
             3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 4'($urandom)};
      send(1 + (i & 1), vr, 0);
    end
    idle(6);

`ifdef WB_LOAD_EXT_EN
    vr = '{2'b10, 2'b10, 16'h0000, 16'h0000, 16'h0000, 16'h12F0, 3'd1, 3'd2, 4'b0100};
    send(1, vr, 0);
    chk("ldext zext", 32'(d1), 32'h00F0);
    vr.md = 4'b1000;
    send(1, vr, 0);
    chk("ldext sext", 32'(d1), 32'hFFF0);
    vr.md = 4'b0000;
    send(1, vr, 0);
    chk("ldext full", 32'(d1), 32'h12F0);
    vr = '{2'b01, 2'b00, 16'h12F0, 16'h0000, 16'h0000, 16'h0000, 3'd3, 3'd2, 4'b0010};
    send(1, vr, 0);
    chk("ldext alu", 32'(d1), 32'h12F0);
    idle(4);
`endif

    chk("final q1 empty", q1.size(), 0);
    chk("final q2 empty", q2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
